// File: rtl/risc_ctrl_seq.sv
// Control sequencer for the small RISC CPU: fetch/latch/execute strobes, retired count, HALT.
// Optional macro CTRL_ILLEGAL_TRAP_EN traps opcodes 0x6-0xE into HALT with a sticky illegal flag.
module risc_ctrl_seq #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             run,
    input  logic [OP_W-1:0]  ir_op,
    input  logic             ac_zero,
    output logic             mem_rd,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             pc_clr,
    output logic             ac_load,
    output logic             ac_inc,
    output logic             ac_clr,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic             illegal_q, illegal_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        mem_rd  = 1'b0;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        pc_clr  = 1'b0;
        ac_load = 1'b0;
        ac_inc  = 1'b0;
        ac_clr  = 1'b0;
        halted  = 1'b0;
        case (state_q)
            // The clear pulse waits for reset release so nothing fires while held in INIT.
            S_INIT: begin
                pc_clr  = clr_n;
                ac_clr  = clr_n;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (run) begin
                    mem_rd  = 1'b1;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_FETCH;
                case (ir_op)
                    OP_W'(4'h0): ;
                    OP_W'(4'h1): ac_load = 1'b1;
                    OP_W'(4'h2): ac_clr  = 1'b1;
                    OP_W'(4'h3): ac_inc  = 1'b1;
                    OP_W'(4'h4): pc_load = 1'b1;
                    OP_W'(4'h5): pc_load = ac_zero;
                    OP_W'(4'hF): state_d = S_HALT;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
`endif
                    end
                endcase
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Scoreboard bench for risc_ctrl_seq: each driven cycle queues its expected outputs,
// a negedge monitor pops and compares them.
module tb_risc_ctrl_seq;

    localparam logic [7:0] S_NONE  = 8'b0000_0000;
    localparam logic [7:0] MEM_RD  = 8'b1000_0000;
    localparam logic [7:0] IR_LOAD = 8'b0100_0000;
    localparam logic [7:0] PC_INC  = 8'b0010_0000;
    localparam logic [7:0] PC_LOAD = 8'b0001_0000;
    localparam logic [7:0] PC_CLR  = 8'b0000_1000;
    localparam logic [7:0] AC_LOAD = 8'b0000_0100;
    localparam logic [7:0] AC_INC  = 8'b0000_0010;
    localparam logic [7:0] AC_CLR  = 8'b0000_0001;

    logic       clk = 1'b0;
    logic       clr_n, run, ac_zero;
    logic [3:0] ir_op;
    logic       mem_rd, ir_load, pc_inc, pc_load, pc_clr, ac_load, ac_inc, ac_clr;
    logic       halted, illegal;
    logic [7:0] instr_cnt;

    logic [17:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  exp_cnt = 8'd0;
    int          errors = 0;
    int          checks = 0;

    risc_ctrl_seq #(.OP_W(4), .CNT_W(8)) dut (
        .clk(clk), .clr_n(clr_n), .run(run), .ir_op(ir_op), .ac_zero(ac_zero),
        .mem_rd(mem_rd), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_clr(pc_clr), .ac_load(ac_load), .ac_inc(ac_inc), .ac_clr(ac_clr),
        .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
    task automatic applyStimulus(input logic cn, input logic r, input logic [3:0] op,
                                 input logic az, input logic [7:0] strobes,
                                 input logic hl, input logic il, input string name,
                                 input bit chk = 1'b1);
        @(posedge clk);
        #1;
        clr_n   = cn;
        run     = r;
        ir_op   = op;
        ac_zero = az;
        if (chk) begin
            exp_q.push_back({strobes, hl, il, exp_cnt});
            name_q.push_back(name);
        end
    endtask

    task automatic checkOutput(input logic [17:0] exp_v, input string name);
        logic [17:0] act_v;
        act_v = {mem_rd, ir_load, pc_inc, pc_load, pc_clr, ac_load, ac_inc, ac_clr,
                 halted, illegal, instr_cnt};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got strobes=%b halted=%b illegal=%b cnt=%0d, want strobes=%b halted=%b illegal=%b cnt=%0d",
                     name, act_v[17:10], act_v[9], act_v[8], act_v[7:0],
                     exp_v[17:10], exp_v[9], exp_v[8], exp_v[7:0]);
        end
    endtask

    // One full instruction with run held high; the count only moves after EXEC.
    task automatic run_instr(input logic [3:0] op, input logic az,
                             input logic [7:0] exec_strobe, input string name);
        applyStimulus(1'b1, 1'b1, op, az, MEM_RD, 1'b0, 1'b0, {name, "_fetch"});
        applyStimulus(1'b1, 1'b1, op, az, IR_LOAD | PC_INC, 1'b0, 1'b0, {name, "_latch"});
        applyStimulus(1'b1, 1'b1, op, az, exec_strobe, 1'b0, 1'b0, {name, "_exec"});
        exp_cnt = exp_cnt + 8'd1;
    endtask

    // Monitor: compare whatever the stimulus side queued for the cycle now settling.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [17:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checkOutput(e, n);
        end
    end

    initial begin
        clr_n = 1'b0; run = 1'b0; ir_op = 4'h0; ac_zero = 1'b0;
        @(posedge clk);
        applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, S_NONE, 1'b0, 1'b0, "reset_held");
        applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, PC_CLR | AC_CLR, 1'b0, 1'b0, "init_pulse");

        run_instr(4'h1, 1'b0, AC_LOAD, "lda");
        run_instr(4'h3, 1'b0, AC_INC, "ina");
        run_instr(4'h2, 1'b0, AC_CLR, "cla");
        run_instr(4'hF, 1'b0, S_NONE, "hlt");
        applyStimulus(1'b1, 1'b1, 4'h1, 1'b0, S_NONE, 1'b1, 1'b0, "halt_run1");
        applyStimulus(1'b1, 1'b0, 4'h1, 1'b0, S_NONE, 1'b1, 1'b0, "halt_run0");
        applyStimulus(1'b1, 1'b1, 4'h4, 1'b1, S_NONE, 1'b1, 1'b0, "halt_stays");

        applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, S_NONE, 1'b1, 1'b0, "reset_from_halt");
        exp_cnt = 8'd0;
        applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, PC_CLR | AC_CLR, 1'b0, 1'b0, "init_after_halt");

        run_instr(4'h5, 1'b1, PC_LOAD, "jz_taken");
        run_instr(4'h5, 1'b0, S_NONE, "jz_not_taken");
        run_instr(4'h4, 1'b0, PC_LOAD, "jmp");
        run_instr(4'h0, 1'b1, S_NONE, "nop");

        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b0, 4'h1, 1'b0, S_NONE, 1'b0, 1'b0, "fetch_stall");
        run_instr(4'h3, 1'b0, AC_INC, "ina_after_stall");

        applyStimulus(1'b1, 1'b1, 4'h1, 1'b0, MEM_RD, 1'b0, 1'b0, "abort_fetch");
        applyStimulus(1'b0, 1'b1, 4'h1, 1'b0, S_NONE, 1'b0, 1'b0, "abort_latch", 1'b0);
        exp_cnt = 8'd0;
        applyStimulus(1'b0, 1'b1, 4'h1, 1'b0, S_NONE, 1'b0, 1'b0, "abort_init_held");
        applyStimulus(1'b1, 1'b1, 4'h1, 1'b0, PC_CLR | AC_CLR, 1'b0, 1'b0, "abort_init_pulse");

        for (int i = 0; i < 256; i++)
            run_instr(4'h0, 1'b0, S_NONE, "nop_wrap");

        run_instr(4'h9, 1'b0, S_NONE, "op9");
`ifdef CTRL_ILLEGAL_TRAP_EN
        applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, S_NONE, 1'b1, 1'b1, "op9_trap");
        applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, S_NONE, 1'b1, 1'b1, "op9_trap_sticky");
`else
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, S_NONE, 1'b0, 1'b0, "op9_nop_fetch");
        run_instr(4'h1, 1'b0, AC_LOAD, "lda_after_op9");
`endif

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
